// File: rtl/loop_monitor.sv
// Instruction-stream loop detector: flags a stream that repeats with a period of
// 1..MAX_PERIOD samples for THRESHOLD consecutive samples. Macro LOOP_MONITOR_STICKY_EN
// latches trigger_o/period_o until rst or clear_i; otherwise they follow the counters.
module loop_monitor #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_PERIOD = 4,
  parameter int THRESHOLD  = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic                  clear_i,
  output logic                  trigger_o,
  output logic [4:0]            period_o
);

  localparam int CNT_W  = $clog2(THRESHOLD + 1);
  localparam int FILL_W = $clog2(MAX_PERIOD + 1);
  localparam logic [CNT_W-1:0]      THR      = CNT_W'(THRESHOLD);
  localparam logic [FILL_W-1:0]     FILL_MAX = FILL_W'(MAX_PERIOD);
  localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] hist_q [MAX_PERIOD];
  logic [DATA_WIDTH-1:0] hist_d [MAX_PERIOD];
  logic [CNT_W-1:0]      cnt_q  [MAX_PERIOD];
  logic [CNT_W-1:0]      cnt_d  [MAX_PERIOD];
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  trigger_q, trigger_d;
  logic [4:0]            period_q, period_d;
  logic                  hit_any;
  logic [4:0]            hit_p;
  logic                  is_nop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == THR) ? c : c + 1'b1;
  endfunction

  function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] f);
    return (f == FILL_MAX) ? f : f + 1'b1;
  endfunction

  always_comb begin
    hist_d    = hist_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    trigger_d = trigger_q;
    period_d  = period_q;
    hit_any   = 1'b0;
    hit_p     = '0;
    is_nop    = (instr_i == NOP_WORD);

    if (clear_i) begin
      // Clear beats a coincident sample: the sample is dropped entirely.
      fill_d = '0;
      for (int p = 0; p < MAX_PERIOD; p++) begin
        cnt_d[p] = '0;
      end
      trigger_d = 1'b0;
      period_d  = '0;
    end else begin
      if (valid_i) begin
        for (int i = MAX_PERIOD - 1; i > 0; i--) begin
          hist_d[i] = hist_q[i-1];
        end
        hist_d[0] = instr_i;
        fill_d    = sat_fill(fill_q);
        // cnt index p covers period p+1, compared against the sample p+1 back.
        for (int p = 0; p < MAX_PERIOD; p++) begin
          if (!is_nop && (int'(fill_q) > p) && (instr_i == hist_q[p])) begin
            cnt_d[p] = sat_inc(cnt_q[p]);
          end else begin
            cnt_d[p] = '0;
          end
        end
      end

      // Descending scan so the smallest hit period is the one left standing.
      for (int p = MAX_PERIOD - 1; p >= 0; p--) begin
        if (cnt_d[p] == THR) begin
          hit_any = 1'b1;
          hit_p   = 5'(p + 1);
        end
      end

`ifdef LOOP_MONITOR_STICKY_EN
      if (!trigger_q) begin
        trigger_d = hit_any;
        period_d  = hit_p;
      end
`else
      trigger_d = hit_any;
      period_d  = hit_p;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q    <= '0;
      cnt_q     <= '{default: '0};
      trigger_q <= 1'b0;
      period_q  <= '0;
    end else begin
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      trigger_q <= trigger_d;
      period_q  <= period_d;
    end
  end

  // History is only ever read below the fill count, so it needs no reset.
  always_ff @(posedge clk) begin
    hist_q <= hist_d;
  end

  assign trigger_o = trigger_q;
  assign period_o  = period_q;

endmodule

// File: doc/loop_monitor.md
LOOP_MONITOR -- requirements
Module: loop_monitor

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the monitored instruction word.
REQ-002 Parameter MAX_PERIOD, default 4: longest loop period detected, in samples; legal range 1..16.
REQ-003 Parameter THRESHOLD, default 50: consecutive matching samples required to fire; legal range 1..255.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 valid_i  input  1  instr_i carries a retired/fetched instruction this cycle.
REQ-007 instr_i  input  DATA_WIDTH  the instruction word sampled when valid_i=1.
REQ-008 clear_i  input  1  synchronous soft clear of all detection state.
REQ-009 trigger_o  output  1  loop detected.
REQ-010 period_o  output  5  period of the detected loop; 0 when trigger_o=0.

Function
REQ-011 The block SHALL hold a history of the last MAX_PERIOD sampled instructions, where hist[0] is the newest, and a fill count saturating at MAX_PERIOD.
REQ-012 On a valid sample, history SHALL shift by one and the fill count SHALL increment; with valid_i=0, all state SHALL hold.
REQ-013 Each period p in 1..MAX_PERIOD SHALL have a counter cnt[p] that saturates at THRESHOLD.
REQ-014 On a valid sample, cnt[p] SHALL increment if fill>=p and instr_i==hist[p-1]; otherwise it SHALL load 0.
REQ-015 A sample with instr_i==32'h00000013 (NOP) SHALL count as a mismatch and zero every counter.
REQ-016 A period p is "hit" when cnt[p]==THRESHOLD.
REQ-017 trigger_o SHALL be registered and high in the cycle after the edge on which any counter reaches THRESHOLD: one-cycle latency, no combinational path from inputs.
REQ-018 period_o SHALL give the smallest hit p, registered alongside trigger_o.
REQ-019 Simultaneous hits SHALL report the smallest p; for example, a period-1 loop also hits p=2 but reports 1.
REQ-020 clear_i=1 SHALL zero the history fill, all counters, trigger_o and period_o on that edge.
REQ-021 When clear_i=1 and valid_i=1 in the same cycle, clear SHALL win and the sample SHALL be discarded.
REQ-022 Saturated counters SHALL hold at THRESHOLD while matches continue; they SHALL NOT wrap.
REQ-023 Counter width SHALL be the minimum needed to hold THRESHOLD.

Reset
REQ-024 rst=1 SHALL set trigger_o=0, period_o=0, every counter to 0 and the fill count to 0; history contents are don't-care.
REQ-025 rst SHALL take priority over clear_i and valid_i, and SHALL abort a partially matched loop mid-count.
REQ-026 The first valid sample after rst deasserts SHALL be treated as the oldest history entry.

Configuration
REQ-027 Macro LOOP_MONITOR_STICKY_EN selects sticky or level trigger behaviour.
REQ-028 With LOOP_MONITOR_STICKY_EN defined:
- Once trigger_o rises, trigger_o and period_o SHALL latch until rst or clear_i.
- Later mismatches SHALL NOT lower trigger_o.
REQ-029 Without LOOP_MONITOR_STICKY_EN:
- trigger_o and period_o SHALL track the current counters each cycle.
- A mismatch SHALL drop trigger_o one cycle after the mismatching sample.

Verification
REQ-030 Period-1 loop: THRESHOLD=4, MAX_PERIOD=4, instr_i=0x0000006F on 5 consecutive valid cycles -> trigger_o=1 and period_o=1 in the cycle after the 5th sample; low before it.
REQ-031 Period-2 loop: THRESHOLD=4, alternate 0x00000513 and 0xFFDFF06F for 6 valid samples -> trigger_o=1 and period_o=2 after the 6th sample.
REQ-032 Gaps and NOP:
- Period-1 stream with valid_i=0 gaps inserted -> same trigger point counted in samples, not cycles.
- Inserting one 0x00000013 after the 3rd sample -> counting restarts and trigger is delayed by 4 samples.
REQ-033 Clear collision: assert clear_i together with valid_i on the 4th of 5 repeated samples -> no trigger; 5 further repeats are then required.
REQ-034 Sticky vs level: trigger a period-1 loop, then feed a differing instruction ->
- With LOOP_MONITOR_STICKY_EN, trigger_o stays 1 until clear_i.
- Without it, trigger_o falls one cycle after the differing sample.
REQ-035 Reset mid-count: rst=1 after 3 matches, then 5 repeats -> trigger only after the 5th post-reset sample; all outputs are 0 during rst.
